// File: rtl/branch_fallback_gen_if.sv
// ============================================================================
// Module      : branch_fallback_gen_pkg / branch_fallback_gen_if
// Description : Shared types and the resolution/update bus used by
//               branch_fallback_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_fallback_gen_pkg;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    NO_BRANCH      = 2'd0,
    PREDICT_TAKEN  = 2'd1,
    PREDICT_TARGET = 2'd2,
    DIRECT_JUMP    = 2'd3
  } predict_t;

  // Prediction record captured at fetch time and carried down the pipe
  typedef struct packed {
    predict_t instr_type;
    logic     is_taken;
    addr_t    target_addr;
  } sbe_predict_t;
endpackage

interface branch_fallback_gen_if #(
  parameter int CNT_W = 32
);
  import branch_fallback_gen_pkg::*;

  // Resolution side (execute/commit -> block)
  logic         res_valid_i;
  logic         res_ready_o;
  addr_t        res_pc_i;
  sbe_predict_t res_predict_i;
  logic         res_taken_i;
  addr_t        res_target_i;

  // Redirect back to fetch
  logic         mispredict_o;
  addr_t        redirect_pc_o;

  // Predictor update stream (block -> BHT/BTB)
  logic         fb_ready_i;
  logic         fb_valid_o;
  addr_t        fb_branch_pc_o;
  logic         fb_branch_taken_o;
  addr_t        fb_target_addr_o;
  predict_t     fb_type_o;

  // Statistics
  logic [CNT_W-1:0] stat_branches_o;
  logic [CNT_W-1:0] stat_mispredicts_o;

  // Environment side: offers resolutions, consumes redirects and updates
  modport master (
    output res_valid_i, res_pc_i, res_predict_i, res_taken_i, res_target_i,
    output fb_ready_i,
    input  res_ready_o, mispredict_o, redirect_pc_o,
    input  fb_valid_o, fb_branch_pc_o, fb_branch_taken_o, fb_target_addr_o, fb_type_o,
    input  stat_branches_o, stat_mispredicts_o
  );

  // Block side
  modport slave (
    input  res_valid_i, res_pc_i, res_predict_i, res_taken_i, res_target_i,
    input  fb_ready_i,
    output res_ready_o, mispredict_o, redirect_pc_o,
    output fb_valid_o, fb_branch_pc_o, fb_branch_taken_o, fb_target_addr_o, fb_type_o,
    output stat_branches_o, stat_mispredicts_o
  );
endinterface

`default_nettype wire

// File: rtl/branch_fallback_gen.sv
// ============================================================================
// Module      : branch_fallback_gen
// Description : Resolution-side branch checker. Flags mispredictions with a
//               registered one-cycle redirect and replays predictor updates
//               from a small circular queue, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_fallback_gen
  import branch_fallback_gen_pkg::*;
#(
  parameter int FB_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic debug_mode_i,
  branch_fallback_gen_if.slave bus
);

  localparam int c_ptr_w = $clog2(FB_DEPTH);
  localparam logic [c_ptr_w:0] c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    addr_t    pc;
    logic     taken;
    addr_t    target;
    predict_t typ;
  } fb_entry_t;

  fb_entry_t          r_mem [FB_DEPTH];
  logic [c_ptr_w:0]   r_head;
  logic [c_ptr_w:0]   r_tail;
  logic               r_mispredict;
  addr_t              r_redirect_pc;
  logic [CNT_W-1:0]   r_stat_br;
  logic [CNT_W-1:0]   r_stat_mis;

  logic               w_empty;
  logic               w_full;
  logic               w_accept;
  logic               w_is_branch;
  logic               w_mispredict;
  logic               w_push;
  logic               w_pop;
  logic               w_fb_valid;
  addr_t              w_redirect_pc;
  fb_entry_t          w_head;
  fb_entry_t          w_new_entry;

  // Full when the pointers agree on index but differ in the wrap bit
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[c_ptr_w] != r_tail[c_ptr_w]) &&
                   (r_head[c_ptr_w-1:0] == r_tail[c_ptr_w-1:0]);

  assign w_accept    = bus.res_valid_i && !w_full;
  assign w_is_branch = (bus.res_predict_i.instr_type != NO_BRANCH);

  // Wrong direction, or right "taken" direction but wrong destination
  assign w_mispredict = w_accept && w_is_branch &&
                        ((bus.res_taken_i != bus.res_predict_i.is_taken) ||
                         (bus.res_taken_i && bus.res_predict_i.is_taken &&
                          (bus.res_target_i != bus.res_predict_i.target_addr)));

  assign w_redirect_pc = bus.res_taken_i ? bus.res_target_i : (bus.res_pc_i + 32'd4);

  // Direction predictions always train; target predictions only on a miss
  assign w_push = w_accept && !debug_mode_i &&
                  ((bus.res_predict_i.instr_type == PREDICT_TAKEN) ||
                   ((bus.res_predict_i.instr_type == PREDICT_TARGET) && w_mispredict));

  assign w_fb_valid = !w_empty && !debug_mode_i;
  assign w_pop      = w_fb_valid && bus.fb_ready_i;

  assign w_new_entry = '{pc:     bus.res_pc_i,
                         taken:  bus.res_taken_i,
                         target: bus.res_target_i,
                         typ:    bus.res_predict_i.instr_type};

  assign w_head = r_mem[r_head[c_ptr_w-1:0]];

  // Queue storage needs no reset: the outputs are masked while empty
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_tail[c_ptr_w-1:0]] <= w_new_entry;
    end
  end

  // Head/tail pointers; reset empties the queue immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + c_ptr_one;
      if (w_pop)  r_head <= r_head + c_ptr_one;
    end
  end

  // One-cycle redirect pulse; the target pc is held between pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_mispredict <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_redirect_pc;
    end
  end

  // Saturating statistics, frozen while the core is halted in debug
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (!debug_mode_i) begin
      if (w_accept && w_is_branch && (r_stat_br != '1)) r_stat_br  <= r_stat_br + c_cnt_one;
      if (w_mispredict && (r_stat_mis != '1))           r_stat_mis <= r_stat_mis + c_cnt_one;
    end
  end

  assign bus.res_ready_o        = !w_full;
  assign bus.mispredict_o       = r_mispredict;
  assign bus.redirect_pc_o      = r_redirect_pc;
  assign bus.fb_valid_o         = w_fb_valid;
  assign bus.fb_branch_pc_o     = w_empty ? '0 : w_head.pc;
  assign bus.fb_branch_taken_o  = w_empty ? 1'b0 : w_head.taken;
  assign bus.fb_target_addr_o   = w_empty ? '0 : w_head.target;
  assign bus.fb_type_o          = w_empty ? NO_BRANCH : w_head.typ;
  assign bus.stat_branches_o    = r_stat_br;
  assign bus.stat_mispredicts_o = r_stat_mis;

endmodule

`default_nettype wire
